// File: rtl/cb_mem_arbiter_pkg.sv
// Shared types for the core-bus memory arbiter: master ids, arbiter states
// and the core-bus request/response bundles.
package cb_mem_arbiter_pkg;

  localparam int CB_ARB_MAX_OUT = 4;

  typedef enum logic {CB_MST_INSTR, CB_MST_LSU} cb_mst_id_t;
  typedef enum logic {ARB_IDLE, ARB_LOCK} cb_arb_st_t;

  // Master-to-slave direction of the AXI-like core bus.
  typedef struct packed {
    logic        ar_valid;
    logic [31:0] ar_addr;
    logic [2:0]  ar_prot;
    logic        r_ready;
    logic        aw_valid;
    logic [31:0] aw_addr;
    logic [2:0]  aw_prot;
    logic        w_valid;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        b_ready;
  } s_cb_mosi_t;

  typedef struct packed {
    logic        ar_ready;
    logic        r_valid;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        aw_ready;
    logic        w_ready;
    logic        b_valid;
    logic [1:0]  b_resp;
  } s_cb_miso_t;

endpackage

// File: rtl/cb_mem_arbiter_fifo.sv
// In-order FIFO of master ids, one entry per outstanding read burst.
module cb_arb_fifo
  import cb_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = CB_ARB_MAX_OUT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  cb_mst_id_t                   id_i,
  input  logic                         pop_i,
  output cb_mst_id_t                   head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  cb_mst_id_t      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= id_i;
  end

endmodule

// File: rtl/cb_mem_arbiter.sv
// Shares one core-bus memory port between fetch (read-only) and LSU masters,
// arbitrating AR and steering read data back in issue order.
module cb_mem_arbiter
  import cb_mem_arbiter_pkg::*;
#(
  parameter int MAX_OUT = CB_ARB_MAX_OUT,
  parameter bit RR_EN   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  s_cb_mosi_t                    instr_cb_mosi_i,
  output s_cb_miso_t                    instr_cb_miso_o,
  input  s_cb_mosi_t                    lsu_cb_mosi_i,
  output s_cb_miso_t                    lsu_cb_miso_o,
  output s_cb_mosi_t                    mem_cb_mosi_o,
  input  s_cb_miso_t                    mem_cb_miso_i,
  output logic [$clog2(MAX_OUT+1)-1:0]  outstanding_o,
  output logic                          orphan_rsp_o
);

  cb_arb_st_t  arb_st_q;
  cb_mst_id_t  grant_q, last_grant_q;
  cb_mst_id_t  grant;
  logic        grant_vld;
  logic        ar_hs;

  cb_mst_id_t  fifo_head;
  logic        fifo_full, fifo_empty, fifo_pop;
  s_cb_mosi_t  sel_mosi;

  logic        unused_instr_wr;

  // A locked grant ignores the other master so the AR payload stays stable.
  always_comb begin
    grant     = CB_MST_INSTR;
    grant_vld = 1'b0;
    if (arb_st_q == ARB_LOCK) begin
      grant     = grant_q;
      grant_vld = (grant_q == CB_MST_LSU) ? lsu_cb_mosi_i.ar_valid
                                          : instr_cb_mosi_i.ar_valid;
    end else if (!fifo_full) begin
      if (RR_EN) begin
        if (instr_cb_mosi_i.ar_valid && lsu_cb_mosi_i.ar_valid)
          grant = (last_grant_q == CB_MST_LSU) ? CB_MST_INSTR : CB_MST_LSU;
        else if (lsu_cb_mosi_i.ar_valid)
          grant = CB_MST_LSU;
      end else if (lsu_cb_mosi_i.ar_valid) begin
        grant = CB_MST_LSU;
      end
      grant_vld = instr_cb_mosi_i.ar_valid || lsu_cb_mosi_i.ar_valid;
    end
  end

  assign sel_mosi = (grant == CB_MST_LSU) ? lsu_cb_mosi_i : instr_cb_mosi_i;
  assign ar_hs    = grant_vld && mem_cb_miso_i.ar_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      arb_st_q     <= ARB_IDLE;
      grant_q      <= CB_MST_INSTR;
      last_grant_q <= CB_MST_LSU;
    end else if (ar_hs) begin
      arb_st_q     <= ARB_IDLE;
      last_grant_q <= grant;
    end else if (grant_vld) begin
      arb_st_q     <= ARB_LOCK;
      grant_q      <= grant;
    end
  end

  cb_arb_fifo #(.DEPTH(MAX_OUT)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ar_hs),
    .id_i    (grant),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

  // With nothing outstanding an R beat has no owner; it is accepted and dropped.
  always_comb begin
    mem_cb_mosi_o   = '0;
    instr_cb_miso_o = '0;
    lsu_cb_miso_o   = '0;

    mem_cb_mosi_o.ar_valid = grant_vld;
    mem_cb_mosi_o.ar_addr  = sel_mosi.ar_addr;
    mem_cb_mosi_o.ar_prot  = sel_mosi.ar_prot;
    if (grant == CB_MST_LSU) lsu_cb_miso_o.ar_ready   = grant_vld && mem_cb_miso_i.ar_ready;
    else                     instr_cb_miso_o.ar_ready = grant_vld && mem_cb_miso_i.ar_ready;

    mem_cb_mosi_o.aw_valid = lsu_cb_mosi_i.aw_valid;
    mem_cb_mosi_o.aw_addr  = lsu_cb_mosi_i.aw_addr;
    mem_cb_mosi_o.aw_prot  = lsu_cb_mosi_i.aw_prot;
    mem_cb_mosi_o.w_valid  = lsu_cb_mosi_i.w_valid;
    mem_cb_mosi_o.w_data   = lsu_cb_mosi_i.w_data;
    mem_cb_mosi_o.w_strb   = lsu_cb_mosi_i.w_strb;
    mem_cb_mosi_o.b_ready  = lsu_cb_mosi_i.b_ready;
    lsu_cb_miso_o.aw_ready = mem_cb_miso_i.aw_ready;
    lsu_cb_miso_o.w_ready  = mem_cb_miso_i.w_ready;
    lsu_cb_miso_o.b_valid  = mem_cb_miso_i.b_valid;
    lsu_cb_miso_o.b_resp   = mem_cb_miso_i.b_resp;

    if (fifo_empty) begin
      mem_cb_mosi_o.r_ready = mem_cb_miso_i.r_valid;
    end else if (fifo_head == CB_MST_LSU) begin
      lsu_cb_miso_o.r_valid = mem_cb_miso_i.r_valid;
      lsu_cb_miso_o.r_data  = mem_cb_miso_i.r_data;
      lsu_cb_miso_o.r_resp  = mem_cb_miso_i.r_resp;
      lsu_cb_miso_o.r_last  = mem_cb_miso_i.r_last;
      mem_cb_mosi_o.r_ready = lsu_cb_mosi_i.r_ready;
    end else begin
      instr_cb_miso_o.r_valid = mem_cb_miso_i.r_valid;
      instr_cb_miso_o.r_data  = mem_cb_miso_i.r_data;
      instr_cb_miso_o.r_resp  = mem_cb_miso_i.r_resp;
      instr_cb_miso_o.r_last  = mem_cb_miso_i.r_last;
      mem_cb_mosi_o.r_ready   = instr_cb_mosi_i.r_ready;
    end
  end

  assign fifo_pop     = !fifo_empty && mem_cb_miso_i.r_valid && mem_cb_mosi_o.r_ready
                        && mem_cb_miso_i.r_last;
  assign orphan_rsp_o = fifo_empty && mem_cb_miso_i.r_valid;

  assign unused_instr_wr = ^{instr_cb_mosi_i.aw_valid, instr_cb_mosi_i.aw_addr,
                             instr_cb_mosi_i.aw_prot, instr_cb_mosi_i.w_valid,
                             instr_cb_mosi_i.w_data, instr_cb_mosi_i.w_strb,
                             instr_cb_mosi_i.b_ready};

  // A master that withdraws AR before its handshake breaks the locked grant.
  ar_held_a: assert property (@(posedge clk) disable iff (rst)
                              (arb_st_q == ARB_LOCK) |-> grant_vld);

endmodule
